// File: rtl/qconv_mem_pkg.sv
// Shared constants for the qconv memory-port arbiter: FSM encoding and requester indices.
package qconv_mem_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_CMD   = ST_CMD,
        S_BURST = ST_BURST,
        S_DONE  = ST_DONE
    } state_t;

    localparam int unsigned REQ_INDATA = 0;
    localparam int unsigned REQ_KERNEL = 1;
    localparam int unsigned REQ_THRESH = 2;
    localparam int unsigned REQ_OUTPUT = 3;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned AW_DEF   = 32;
    localparam int unsigned LW_DEF   = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [IW:0] cand;

    // Scan ptr, ptr+1, ... and keep the first hit.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/qconv_mem_arbiter.sv
// Round-robin owner of the single memory burst port shared by the qconv transfer engines.
module qconv_mem_arbiter
    import qconv_mem_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned LW   = LW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*LW-1:0] req_len,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    req_done,
    output logic [NREQ-1:0]    grant,
    output logic               mem_cmd_valid,
    input  logic               mem_cmd_ready,
    output logic [AW-1:0]      mem_cmd_addr,
    output logic [LW-1:0]      mem_cmd_len,
    output logic               mem_cmd_write,
    input  logic               mem_beat,
    output logic               busy,
    output logic               err_stray_beat
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic          err_q, err_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [NREQ-1:0] idx_oh;

    logic [AW-1:0] addr_arr [NREQ];
    logic [LW-1:0] len_arr  [NREQ];

    // Unpack the flat per-requester command fields.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*AW +: AW];
        assign len_arr[g]  = req_len[g*LW +: LW];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign idx_oh         = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
    assign mem_cmd_addr   = addr_q;
    assign mem_cmd_len    = len_q;
    assign mem_cmd_write  = write_q;
    assign err_stray_beat = err_q;

    // State, pointer, latched command and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(REQ_INDATA);
            idx_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    // Next-state sequencing and per-requester handshake decode.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        err_d         = err_q;
        req_ack       = '0;
        req_done      = '0;
        grant         = '0;
        mem_cmd_valid = 1'b0;
        busy          = (state_q != S_IDLE);

        // Beats are only meaningful inside a burst; anything else is flagged and dropped.
        if (mem_beat && (state_q != S_BURST)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    addr_d  = addr_arr[pick_idx];
                    len_d   = len_arr[pick_idx];
                    write_d = req_write[pick_idx];
                    state_d = (len_arr[pick_idx] != '0) ? S_CMD : S_DONE;
                end
            end
            S_CMD: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    req_ack = idx_oh;
                    grant   = idx_oh;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                grant = idx_oh;
                if (mem_beat) begin
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_q == len_q - LW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                grant    = idx_oh;
                req_done = idx_oh;
                // A zero-length command never reaches CMD, so it is acknowledged here.
                if (len_q == '0) begin
                    req_ack = idx_oh;
                end
                ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qconv_mem_arbiter.sv
// Self-checking bench for qconv_mem_arbiter: directed scenarios plus a randomized scoreboard run.
module tb_qconv_mem_arbiter;
    import qconv_mem_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 32;
    localparam int unsigned LW   = 8;
    localparam int          NCMD = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid, req_write, req_ack, req_done, grant;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*LW-1:0]  req_len;
    logic                mem_cmd_valid, mem_cmd_ready, mem_cmd_write, mem_beat, busy, err_stray_beat;
    logic [AW-1:0]       mem_cmd_addr;
    logic [LW-1:0]       mem_cmd_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qconv_mem_arbiter #(.NREQ(NREQ), .AW(AW), .LW(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_ack        (req_ack),
        .req_done       (req_done),
        .grant          (grant),
        .mem_cmd_valid  (mem_cmd_valid),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_cmd_addr   (mem_cmd_addr),
        .mem_cmd_len    (mem_cmd_len),
        .mem_cmd_write  (mem_cmd_write),
        .mem_beat       (mem_beat),
        .busy           (busy),
        .err_stray_beat (err_stray_beat)
    );

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic clear_inputs();
        req_valid     = '0;
        req_write     = '0;
        req_addr      = '0;
        req_len       = '0;
        mem_cmd_ready = 1'b0;
        mem_beat      = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l, input logic w);
        req_addr[i*AW +: AW] = a;
        req_len[i*LW +: LW]  = l;
        req_write[i]         = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [55:0] outs;
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        mem_cmd_ready = 1'b1;
        mem_beat = 1'b1;
        set_req(0, 32'hDEAD_BEEF, 8'd9, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            outs = {req_ack, req_done, grant, mem_cmd_valid, mem_cmd_addr, mem_cmd_len,
                    mem_cmd_write, busy, err_stray_beat};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", c, outs);
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        set_req(REQ_KERNEL, 32'h100, 8'd5, 1'b0);
        req_valid = 4'b0010;
        mem_cmd_ready = 1'b1;
        #1;
        checks++;
        if (mem_cmd_valid !== 1'b0) begin errors++; $display("FAIL single_cmd_early: got %b want 0", mem_cmd_valid); end
        @(negedge clk); #1;
        checks++;
        if ({mem_cmd_valid, mem_cmd_addr, mem_cmd_len, mem_cmd_write} !== {1'b1, 32'h100, 8'd5, 1'b0}) begin
            errors++;
            $display("FAIL single_cmd: got v=%b a=%h l=%0d w=%b want v=1 a=100 l=5 w=0",
                     mem_cmd_valid, mem_cmd_addr, mem_cmd_len, mem_cmd_write);
        end
        checks++;
        if ({req_ack, grant} !== {4'b0010, 4'b0010}) begin
            errors++; $display("FAIL single_ack_grant: got ack=%b grant=%b want 0010/0010", req_ack, grant);
        end
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            req_valid = '0;
            mem_beat = 1'b1;
            #1;
            checks++;
            if ({grant, req_done} !== {4'b0010, 4'b0000}) begin
                errors++; $display("FAIL single_burst[%0d]: got grant=%b done=%b want 0010/0000", b, grant, req_done);
            end
        end
        @(negedge clk); mem_beat = 1'b0; #1;
        checks++;
        if ({req_done, req_ack, busy} !== {4'b0010, 4'b0000, 1'b1}) begin
            errors++; $display("FAIL single_done: got done=%b ack=%b busy=%b want 0010/0000/1", req_done, req_ack, busy);
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, grant, req_done} !== 9'b0) begin
            errors++; $display("FAIL single_idle: got busy=%b grant=%b done=%b want 0", busy, grant, req_done);
        end
    endtask

    task automatic test_fairness();
        int last [NREQ];
        int obs, gap, w;
        logic found;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, AW'(32'h1000 * (i + 1)), 8'd2, i[0]);
            last[i] = -1;
        end
        req_valid = '1;
        mem_cmd_ready = 1'b1;
        for (int k = 0; k < 2 * NREQ; k++) begin
            found = 1'b0;
            w = 0;
            while (w < 12) begin
                @(negedge clk); mem_beat = 1'b0; #1;
                if (mem_cmd_valid) begin found = 1'b1; break; end
                w++;
            end
            checks++;
            if (!found) begin errors++; $display("FAIL fair_timeout[%0d]: got no command want command", k); break; end
            obs = -1;
            for (int i = 0; i < NREQ; i++) if (req_ack[i]) obs = i;
            checks++;
            if (req_ack !== oh(k % NREQ)) begin
                errors++; $display("FAIL fair_order[%0d]: got ack=%b want %b", k, req_ack, oh(k % NREQ));
            end
            checks++;
            if (mem_cmd_addr !== AW'(32'h1000 * ((k % NREQ) + 1))) begin
                errors++; $display("FAIL fair_addr[%0d]: got %h want %h", k, mem_cmd_addr, 32'h1000 * ((k % NREQ) + 1));
            end
            if (obs >= 0) begin
                gap = k - last[obs] - 1;
                checks++;
                if (gap > NREQ - 1) begin errors++; $display("FAIL fair_wait[%0d]: got %0d bursts want <= 3", k, gap); end
                last[obs] = k;
            end
            for (int b = 0; b < 2; b++) begin @(negedge clk); mem_beat = 1'b1; end
            @(negedge clk); mem_beat = 1'b0; #1;
            checks++;
            if (req_done !== oh(k % NREQ)) begin
                errors++; $display("FAIL fair_done[%0d]: got %b want %b", k, req_done, oh(k % NREQ));
            end
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        set_req(REQ_OUTPUT, 32'hABCD_0000, 8'd3, 1'b1);
        req_valid = 4'b1000;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            set_req(REQ_OUTPUT, $urandom(), LW'($urandom_range(1, 255)), 1'b0);
            #1;
            checks++;
            if ({mem_cmd_valid, mem_cmd_addr, mem_cmd_len, mem_cmd_write} !== {1'b1, 32'hABCD_0000, 8'd3, 1'b1}) begin
                errors++;
                $display("FAIL bp_stable[%0d]: got v=%b a=%h l=%0d w=%b want v=1 a=abcd0000 l=3 w=1",
                         c, mem_cmd_valid, mem_cmd_addr, mem_cmd_len, mem_cmd_write);
            end
            checks++;
            if ({req_ack, grant} !== 8'b0) begin
                errors++; $display("FAIL bp_no_ack[%0d]: got ack=%b grant=%b want 0", c, req_ack, grant);
            end
        end
        @(negedge clk); mem_cmd_ready = 1'b1; #1;
        checks++;
        if ({mem_cmd_valid, req_ack, grant} !== {1'b1, 4'b1000, 4'b1000}) begin
            errors++; $display("FAIL bp_accept: got v=%b ack=%b grant=%b want 1/1000/1000", mem_cmd_valid, req_ack, grant);
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); req_valid = '0; mem_cmd_ready = 1'b0; mem_beat = 1'b1;
        end
        @(negedge clk); mem_beat = 1'b0; #1;
        checks++;
        if (req_done !== 4'b1000) begin errors++; $display("FAIL bp_done: got %b want 1000", req_done); end
    endtask

    task automatic test_zero_len();
        do_reset();
        @(negedge clk);
        set_req(REQ_THRESH, 32'h3000, 8'd0, 1'b0);
        req_valid = 4'b0100;
        mem_cmd_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({mem_cmd_valid, req_ack, req_done} !== {1'b0, 4'b0100, 4'b0100}) begin
            errors++; $display("FAIL zero_ack_done: got v=%b ack=%b done=%b want 0/0100/0100", mem_cmd_valid, req_ack, req_done);
        end
        @(negedge clk);
        set_req(REQ_KERNEL, 32'h1111_0000, 8'd1, 1'b0);
        set_req(REQ_OUTPUT, 32'h3333_0000, 8'd1, 1'b1);
        req_valid = 4'b1010;
        #1;
        checks++;
        if ({mem_cmd_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL zero_idle: got v=%b busy=%b want 0/0", mem_cmd_valid, busy);
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_cmd_valid, mem_cmd_addr, req_ack} !== {1'b1, 32'h3333_0000, 4'b1000}) begin
            errors++; $display("FAIL zero_ptr_adv: got v=%b a=%h ack=%b want 1/33330000/1000", mem_cmd_valid, mem_cmd_addr, req_ack);
        end
        @(negedge clk); req_valid = '0; mem_beat = 1'b1;
        @(negedge clk); mem_beat = 1'b0; #1;
        checks++;
        if (req_done !== 4'b1000) begin errors++; $display("FAIL zero_next_done: got %b want 1000", req_done); end
    endtask

    task automatic test_random();
        logic [AW-1:0] t_addr [NREQ][NCMD];
        logic [LW-1:0] t_len  [NREQ][NCMD];
        logic          t_wr   [NREQ][NCMD];
        int head [NREQ];
        int ptr, ph, cur, left, served, exp_i, cand, r;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            for (int j = 0; j < NCMD; j++) begin
                r = int'($urandom_range(0, 15));
                t_addr[i][j] = $urandom();
                t_len[i][j]  = (r == 15) ? 8'd255 : LW'(r);
                t_wr[i][j]   = 1'($urandom_range(0, 1));
            end
        end
        ptr = 0; ph = 0; cur = 0; left = 0; served = 0;
        for (int cyc = 0; cyc < 8000 && served < NREQ * NCMD; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (head[i] < NCMD);
                if (head[i] < NCMD) set_req(i, t_addr[i][head[i]], t_len[i][head[i]], t_wr[i][head[i]]);
            end
            mem_cmd_ready = ($urandom_range(0, 2) != 0);
            mem_beat = (ph == 2) && ($urandom_range(0, 3) != 0);
            #1;
            if (ph == 0 && (mem_cmd_valid || req_done != '0)) begin
                exp_i = -1;
                for (int k = 0; k < NREQ; k++) begin
                    cand = (ptr + k) % NREQ;
                    if (exp_i < 0 && head[cand] < NCMD) exp_i = cand;
                end
                checks++;
                if (exp_i < 0) begin errors++; $display("FAIL rnd_spurious: got activity want none pending"); exp_i = 0; end
                cur = exp_i;
                if (mem_cmd_valid) begin
                    ph = 1;
                end else begin
                    checks++;
                    if ({req_ack, req_done} !== {oh(cur), oh(cur)} || t_len[cur][head[cur]] != '0) begin
                        errors++;
                        $display("FAIL rnd_zero: got ack=%b done=%b want %b for len %0d", req_ack, req_done, oh(cur), t_len[cur][head[cur]]);
                    end
                    head[cur]++; served++; ptr = (cur + 1) % NREQ;
                end
            end else if (ph == 0) begin
                checks++;
                if ({req_ack, req_done, grant} !== 12'b0) begin
                    errors++; $display("FAIL rnd_idle: got ack=%b done=%b grant=%b want 0", req_ack, req_done, grant);
                end
            end
            if (ph == 1) begin
                checks++;
                if ({mem_cmd_valid, mem_cmd_addr, mem_cmd_len, mem_cmd_write} !==
                    {1'b1, t_addr[cur][head[cur]], t_len[cur][head[cur]], t_wr[cur][head[cur]]}) begin
                    errors++;
                    $display("FAIL rnd_cmd: got v=%b a=%h l=%0d w=%b want req %0d a=%h l=%0d w=%b", mem_cmd_valid,
                             mem_cmd_addr, mem_cmd_len, mem_cmd_write, cur, t_addr[cur][head[cur]],
                             t_len[cur][head[cur]], t_wr[cur][head[cur]]);
                end
                checks++;
                if (mem_cmd_ready) begin
                    if ({req_ack, grant} !== {oh(cur), oh(cur)}) begin
                        errors++; $display("FAIL rnd_accept: got ack=%b grant=%b want %b", req_ack, grant, oh(cur));
                    end
                    left = int'(t_len[cur][head[cur]]);
                    head[cur]++;
                    ph = 2;
                end else if (req_ack !== '0) begin
                    errors++; $display("FAIL rnd_early_ack: got %b want 0000", req_ack);
                end
            end else if (ph == 2) begin
                checks++;
                if ({grant, req_done} !== {oh(cur), 4'b0000}) begin
                    errors++; $display("FAIL rnd_burst: got grant=%b done=%b want %b/0000", grant, req_done, oh(cur));
                end
                if (mem_beat) begin
                    left--;
                    if (left == 0) ph = 3;
                end
            end else if (ph == 3) begin
                checks++;
                if ({req_done, req_ack} !== {oh(cur), 4'b0000}) begin
                    errors++; $display("FAIL rnd_done: got done=%b ack=%b want %b/0000", req_done, req_ack, oh(cur));
                end
                served++; ptr = (cur + 1) % NREQ; ph = 0;
            end
        end
        checks++;
        if (served != NREQ * NCMD) begin errors++; $display("FAIL rnd_timeout: got %0d served want %0d", served, NREQ * NCMD); end
        checks++;
        if (err_stray_beat !== 1'b0) begin errors++; $display("FAIL rnd_stray: got %b want 0", err_stray_beat); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [55:0] outs;
        do_reset();
        @(negedge clk);
        set_req(REQ_INDATA, 32'h2000, 8'd8, 1'b0);
        req_valid = 4'b0001;
        mem_cmd_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (req_ack !== 4'b0001) begin errors++; $display("FAIL rmid_ack: got %b want 0001", req_ack); end
        for (int b = 0; b < 3; b++) begin @(negedge clk); mem_beat = 1'b1; end
        @(negedge clk); mem_beat = 1'b0; rst_n = 1'b0; #1;
        outs = {req_ack, req_done, grant, mem_cmd_valid, mem_cmd_addr, mem_cmd_len, mem_cmd_write, busy, err_stray_beat};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL rmid_async: got %h want 0", outs); end
        repeat (2) begin
            @(negedge clk); #1;
            checks++;
            if ({req_done, busy} !== 5'b0) begin errors++; $display("FAIL rmid_hold: got done=%b busy=%b want 0", req_done, busy); end
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if ({mem_cmd_valid, req_done, busy} !== 6'b0) begin
            errors++; $display("FAIL rmid_release: got v=%b done=%b busy=%b want 0", mem_cmd_valid, req_done, busy);
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_cmd_valid, mem_cmd_addr, mem_cmd_len, req_ack} !== {1'b1, 32'h2000, 8'd8, 4'b0001}) begin
            errors++; $display("FAIL rmid_fresh_cmd: got v=%b a=%h l=%0d ack=%b want 1/2000/8/0001",
                               mem_cmd_valid, mem_cmd_addr, mem_cmd_len, req_ack);
        end
        for (int b = 0; b < 8; b++) begin
            @(negedge clk); req_valid = '0; mem_cmd_ready = 1'b0; mem_beat = 1'b1; #1;
            checks++;
            if (req_done !== 4'b0000) begin errors++; $display("FAIL rmid_early_done[%0d]: got %b want 0000", b, req_done); end
        end
        @(negedge clk); mem_beat = 1'b0; #1;
        checks++;
        if (req_done !== 4'b0001) begin errors++; $display("FAIL rmid_done: got %b want 0001", req_done); end
    endtask

    task automatic test_stray();
        do_reset();
        @(negedge clk); mem_beat = 1'b1; #1;
        checks++;
        if (err_stray_beat !== 1'b0) begin errors++; $display("FAIL stray_pre: got %b want 0", err_stray_beat); end
        @(negedge clk); mem_beat = 1'b0; #1;
        checks++;
        if ({err_stray_beat, busy} !== 2'b10) begin
            errors++; $display("FAIL stray_set: got err=%b busy=%b want 1/0", err_stray_beat, busy);
        end
        @(negedge clk);
        set_req(REQ_KERNEL, 32'h4000, 8'd2, 1'b1);
        req_valid = 4'b0010;
        mem_cmd_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({mem_cmd_valid, req_ack} !== {1'b1, 4'b0010}) begin
            errors++; $display("FAIL stray_serve: got v=%b ack=%b want 1/0010", mem_cmd_valid, req_ack);
        end
        for (int b = 0; b < 2; b++) begin @(negedge clk); req_valid = '0; mem_beat = 1'b1; end
        @(negedge clk); mem_beat = 1'b0; #1;
        checks++;
        if ({req_done, err_stray_beat} !== {4'b0010, 1'b1}) begin
            errors++; $display("FAIL stray_sticky: got done=%b err=%b want 0010/1", req_done, err_stray_beat);
        end
        do_reset();
        #1;
        checks++;
        if (err_stray_beat !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b want 0", err_stray_beat); end
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_zero_len();
        test_random();
        test_reset_mid();
        test_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/qconv_mem_arbiter.md
Name: qconv_mem_arbiter

Overview:
- Round-robin scheduler that shares the single external memory burst port of the qconv engine between its loop-level transfer engines: input-data read, kernel read, thresholds read and output write.
- Each requester posts one burst command and receives a one-cycle ack when the memory accepts it, then a one-cycle done pulse after the last data beat.
- The block counts beats and holds a one-hot grant for the data-path mux.
- It sits between the qconv loop state machines and the memory interface.

Parameters:
- NREQ, 4, number of requesters; index 0=indata, 1=kernel, 2=thresholds, 3=output.
- AW, 32, burst address width.
- LW, 8, burst length width, in beats.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester command pending.
- req_write  in  NREQ  1 = write burst, 0 = read burst.
- req_addr  in  NREQ*AW  packed start addresses; requester i is at bits [i*AW +: AW].
- req_len  in  NREQ*LW  packed beat counts; requester i is at bits [i*LW +: LW].
- req_ack  out  NREQ  one-cycle pulse when the requester's command is accepted, or absorbed if len=0.
- req_done  out  NREQ  one-cycle pulse when the requester's burst is complete.
- grant  out  NREQ  one-hot owner, valid from ack until done; zero when idle.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  memory accepts the command.
- mem_cmd_addr  out  AW  registered command address.
- mem_cmd_len  out  LW  registered command length.
- mem_cmd_write  out  1  registered command direction.
- mem_beat  in  1  one data beat transferred this cycle.
- busy  out  1  high in any state except IDLE.
- err_stray_beat  out  1  sticky flag: mem_beat seen outside BURST.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr pointer=0, beat count=0.
  - All outputs 0.
  - Reset mid-burst abandons the burst; no done pulse is issued.
- States: IDLE, CMD, BURST, DONE.
- IDLE:
  - If any req_valid is set, select the first set bit scanning pointer, pointer+1, … modulo NREQ.
  - Latch index, addr, len and write into registers.
  - Next state is CMD if len≠0, else DONE.
  - No other state samples req_valid, addr, len or write.
- CMD:
  - mem_cmd_valid=1 with the latched fields held stable.
  - When mem_cmd_ready=1: req_ack[idx] pulses in that same cycle, grant=onehot(idx) from that same cycle, beat count is cleared, next state BURST.
- BURST:
  - Each mem_beat increments the beat count.
  - When mem_beat=1 and count==len-1, go to DONE.
- DONE (exactly one cycle):
  - req_done[idx]=1.
  - For len=0, req_ack[idx] also pulses in this cycle.
  - pointer <= idx+1, wrapping to 0 after NREQ-1.
  - grant is cleared on exit; next state IDLE.
- Latency:
  - req_valid sampled at cycle t gives mem_cmd_valid at t+1.
  - Last beat at cycle b gives req_done at b+1 and IDLE at b+2.
  - The earliest next mem_cmd_valid is at b+3.
- Requester contract:
  - Hold req_valid until req_ack, then drop or re-post.
  - A request dropped before it is selected is simply not served.
- Length width:
  - len is unsigned, maximum 2^LW-1 beats.
  - The beat counter is LW bits and never wraps within a legal burst.
- Simultaneous requests: only one is selected per IDLE cycle; the others wait, and the pointer guarantees each is served within NREQ bursts.
- mem_beat in IDLE, CMD or DONE sets err_stray_beat, which clears only on reset; the beat is ignored otherwise.
- At most one bit of req_ack, req_done and grant is ever set.

Decomposition:
- Package qconv_mem_pkg holds:
  - State encoding constants ST_IDLE=0, ST_CMD=1, ST_BURST=2, ST_DONE=3.
  - Requester index constants REQ_INDATA=0, REQ_KERNEL=1, REQ_THRESH=2, REQ_OUTPUT=3.
- Sub-module rr_pick (combinational): inputs req vector and pointer; outputs a found flag and the selected index.
- Sequencing, the latching registers and the beat counter stay in qconv_mem_arbiter.

Test Plan:
- Single request: only req 1 (kernel) posted with addr=0x100, len=5, write=0, ready tied high.
  - mem_cmd_valid 1 cycle after req_valid, addr=0x100, len=5.
  - ack[1] in the same cycle as cmd accept.
  - done[1] exactly 1 cycle after the 5th mem_beat; busy low 1 cycle later.
- Fairness: all 4 requests held continuously from reset, len=2 each.
  - Service order is 0,1,2,3,0,1…
  - No requester waits more than 3 bursts.
- Backpressure: mem_cmd_ready held low 7 cycles.
  - mem_cmd_valid and its fields stay stable.
  - No ack until ready; ack and grant appear in the ready cycle.
- Zero length: req 2 posted with len=0.
  - No mem_cmd_valid.
  - ack[2] and done[2] pulse together 1 cycle after selection; pointer advances to 3.
- Reset mid-burst: rst_n=0 after 3 of 8 beats.
  - All outputs 0 immediately (async).
  - No done pulse; after release, the pending req 0 is served from a fresh command.
- Stray beat: mem_beat pulsed in IDLE.
  - err_stray_beat=1 and stays 1 through later normal bursts until reset.
